// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side handshake signals for mem_arbiter.
// slave = arbiter view, master = requester/memory (environment) view.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        ifu_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        lsu_err;

    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_resp_valid;
    logic        m_resp_ready;
    logic [31:0] m_rdata;
    logic        m_resp_err;

    logic        timeout_flag;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output m_req_valid, m_addr, m_wen, m_wdata, m_wmask, m_resp_ready,
        input  m_req_ready, m_resp_valid, m_rdata, m_resp_err,
        output timeout_flag
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  m_req_valid, m_addr, m_wen, m_wdata, m_wmask, m_resp_ready,
        output m_req_ready, m_resp_valid, m_rdata, m_resp_err,
        input  timeout_flag
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter with response timeout.
// CONFIG_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise LSU has fixed priority.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  io_bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DELIVER
    } state_t;

    state_t        r_state;
    logic          r_id;          // 1 = LSU owns the transaction, 0 = IFU
    logic [31:0]   r_addr;
    logic          r_wen;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wmask;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
`ifdef CONFIG_ARB_ROUND_ROBIN_EN
    logic          r_last_lsu;
`endif

    logic          w_any;
    logic          w_win_lsu;
    logic          w_grant;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_to;
    logic          w_resp_rdy;

    assign w_any = io_bus.ifu_req_valid | io_bus.lsu_req_valid;

`ifdef CONFIG_ARB_ROUND_ROBIN_EN
    // On contention hand the grant to whoever did not get the previous one.
    assign w_win_lsu = io_bus.lsu_req_valid & (~io_bus.ifu_req_valid | ~r_last_lsu);
`else
    assign w_win_lsu = io_bus.lsu_req_valid;
`endif

    // rst gates the grant so no ready escapes while the flops are held in reset.
    assign w_grant    = (r_state == S_IDLE) & ~rst & w_any;
    assign w_cnt_nxt  = r_cnt + CW'(1);
    assign w_to       = (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
    assign w_resp_rdy = r_id ? io_bus.lsu_resp_ready : io_bus.ifu_resp_ready;

    assign io_bus.ifu_req_ready  = w_grant & ~w_win_lsu;
    assign io_bus.lsu_req_ready  = w_grant &  w_win_lsu;
    assign io_bus.ifu_resp_valid = (r_state == S_DELIVER) & ~r_id;
    assign io_bus.lsu_resp_valid = (r_state == S_DELIVER) &  r_id;
    assign io_bus.ifu_rdata      = r_rdata;
    assign io_bus.lsu_rdata      = r_rdata;
    assign io_bus.ifu_err        = r_err;
    assign io_bus.lsu_err        = r_err;

    assign io_bus.m_req_valid    = (r_state == S_REQ);
    // Stale responses are drained everywhere except while a result is being held.
    assign io_bus.m_resp_ready   = (r_state != S_DELIVER);
    assign io_bus.m_addr         = r_addr;
    assign io_bus.m_wen          = r_wen;
    assign io_bus.m_wdata        = r_wdata;
    assign io_bus.m_wmask        = r_wmask;
    assign io_bus.timeout_flag   = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_id       <= 1'b0;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
`ifdef CONFIG_ARB_ROUND_ROBIN_EN
            r_last_lsu <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win_lsu;
                        r_addr  <= w_win_lsu ? io_bus.lsu_addr : io_bus.ifu_addr;
                        r_wen   <= w_win_lsu & io_bus.lsu_wen;
                        r_wdata <= w_win_lsu ? io_bus.lsu_wdata : 32'h0;
                        r_wmask <= w_win_lsu ? io_bus.lsu_wmask : 4'h0;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Timeout wins here so the counter never runs past its limit.
                    if (w_to) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_DELIVER;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (io_bus.m_req_ready)
                            r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (io_bus.m_resp_valid) begin
                        r_rdata <= io_bus.m_rdata;
                        r_err   <= io_bus.m_resp_err;
                        r_state <= S_DELIVER;
                    end else if (w_to) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_DELIVER;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DELIVER: begin
                    if (w_resp_rdy) begin
`ifdef CONFIG_ARB_ROUND_ROBIN_EN
                        r_last_lsu <= r_id;
`endif
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles from entering REQ to receiving m_resp_valid before the arbiter aborts with an error.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-003 SHALL have IFU read-only requester ports:
- ifu_req_valid in 1; ifu_req_ready out 1
- ifu_addr in 32
- ifu_resp_valid out 1; ifu_resp_ready in 1
- ifu_rdata out 32; ifu_err out 1
REQ-004 SHALL have LSU requester ports:
- lsu_req_valid in 1; lsu_req_ready out 1
- lsu_addr in 32; lsu_wen in 1; lsu_wdata in 32; lsu_wmask in 4
- lsu_resp_valid out 1; lsu_resp_ready in 1
- lsu_rdata out 32; lsu_err out 1
REQ-005 SHALL have memory-side ports:
- m_req_valid out 1; m_req_ready in 1
- m_addr out 32; m_wen out 1; m_wdata out 32; m_wmask out 4
- m_resp_valid in 1; m_resp_ready out 1
- m_rdata in 32; m_resp_err in 1
REQ-006 SHALL have timeout_flag (out, 1): sticky, set on any timeout.

Function
REQ-007 SHALL implement states IDLE, REQ, RESP, DELIVER.
REQ-008 IDLE, any req_valid high: select a winner combinationally; assert only the winner's req_ready in the same cycle; latch the winner's payload and ID; go to REQ next cycle. IFU payload latches as wen=0, wmask=0, wdata=0.
REQ-009 REQ: m_req_valid=1 with the latched payload; on m_req_ready go to RESP.
REQ-010 RESP: m_resp_ready=1; on m_resp_valid latch m_rdata and m_resp_err, then go to DELIVER.
REQ-011 DELIVER: assert the winner's resp_valid with the latched rdata/err; the other requester's resp_valid stays 0; on the winner's resp_ready go to IDLE and record the winner as last_grant.
REQ-012 Minimum latency, request accept to resp_valid: 3 cycles with m_req_ready and m_resp_valid both immediate.
REQ-013 req_ready SHALL be 0 in every state except IDLE; at most one req_ready and at most one resp_valid high per cycle.
REQ-014 Timeout counter:
- clears to 0 on entering REQ; increments each cycle in REQ or RESP
- on reaching TIMEOUT_CYCLES: go to DELIVER with err=1, rdata=0; set timeout_flag
REQ-015 A late or stale m_resp_valid outside RESP SHALL be accepted (m_resp_ready=1 in IDLE and REQ) and discarded; m_resp_ready=0 in DELIVER.
REQ-016 Latched payload and response SHALL be held stable while in REQ and DELIVER regardless of requester inputs.

Reset
REQ-017 rst SHALL immediately force:
- state IDLE; last_grant=LSU; counter 0; timeout_flag 0
- all req_ready, resp_valid, m_req_valid outputs 0; m_resp_ready per IDLE (1)
- rdata/err/m_addr/m_wdata/m_wmask/m_wen 0
REQ-018 Reset mid-transaction SHALL abandon the transaction with no response delivered.

Configuration
REQ-019 Macro CONFIG_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not equal to last_grant; first contention after reset goes to IFU.
REQ-020 Macro undefined: fixed priority, LSU always wins over IFU; last_grant is unused.

Verification
REQ-021 IFU only, addr 0x80000000, memory ready immediate, rdata 0xDEADBEEF -> ifu_resp_valid 3 cycles after accept, ifu_rdata 0xDEADBEEF, ifu_err 0.
REQ-022 IFU and LSU both request in the same IDLE cycle, 4 back-to-back rounds -> RR build: grants IFU, LSU, IFU, LSU; fixed build: LSU on every round while LSU keeps requesting.
REQ-023 LSU write, addr 0x80001004, wdata 0x12345678, wmask 0xF, m_req_ready delayed 5 cycles -> m_* outputs stable for all 5 cycles; exactly one memory request issued.
REQ-024 m_resp_valid withheld, TIMEOUT_CYCLES=8 -> requester gets resp_valid with err=1, rdata=0; timeout_flag=1; a later m_resp_valid is discarded with no resp_valid to either requester.
REQ-025 rst asserted during RESP -> all outputs take reset values in the same cycle; the next IFU request completes normally.
REQ-026 resp_ready held 0 for 4 cycles in DELIVER -> resp_valid/rdata stable; ifu_req_ready and lsu_req_ready stay 0 throughout.
